// File: rtl/btb_predict_ctrl.sv
// -----------------------------------------------------------------------------
// btb_predict_ctrl
//
// Controller for a branch target buffer. It owns the BTB write port, keeps a
// valid bit and a 2-bit saturating direction counter per entry, and forms the
// fetch-stage taken/target prediction. EX-stage branch resolutions are queued
// in a small FIFO and committed one per cycle. After reset or flush every
// entry is swept clear before normal operation resumes.
//
// Ports
//   i_Clk, i_Reset              clock, asynchronous active-high reset
//   i_pc, i_btb_target          fetch lookup index and BTB read data
//   o_predict_taken             valid & counter MSB, forced low while sweeping
//   o_pred_target               predicted target (BTB read data)
//   i_upd_valid / o_upd_ready   EX update handshake
//   i_upd_pc/_taken/_target     resolved branch
//   i_flush                     invalidate all entries (restart sweep)
//   o_btb_wr_en/_idx/_target    BTB write port
//   o_busy                      sweep in progress
//   o_fifo_count                queued update count
// -----------------------------------------------------------------------------
module btb_predict_ctrl #(
   parameter int ADDRESS_WIDTH = 22,
   parameter int BUFFER_SIZE   = 8,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                         i_Clk,
   input  logic                         i_Reset,
   input  logic [BUFFER_SIZE-1:0]       i_pc,
   input  logic [ADDRESS_WIDTH-1:0]     i_btb_target,
   output logic                         o_predict_taken,
   output logic [ADDRESS_WIDTH-1:0]     o_pred_target,
   input  logic                         i_upd_valid,
   output logic                         o_upd_ready,
   input  logic [BUFFER_SIZE-1:0]       i_upd_pc,
   input  logic                         i_upd_taken,
   input  logic [ADDRESS_WIDTH-1:0]     i_upd_target,
   input  logic                         i_flush,
   output logic                         o_btb_wr_en,
   output logic [BUFFER_SIZE-1:0]       o_btb_wr_idx,
   output logic [ADDRESS_WIDTH-1:0]     o_btb_wr_target,
   output logic                         o_busy,
   output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count
);

   localparam int NUM_ENTRIES = 2**BUFFER_SIZE;
   localparam int PTR_W       = $clog2(FIFO_DEPTH) + 1;
   localparam int FIFO_AW     = PTR_W - 1;

   typedef enum logic {ST_SWEEP, ST_RUN} state_t;

   state_t                    r_state;
   logic [BUFFER_SIZE-1:0]    r_sweep_idx;
   logic [PTR_W-1:0]          r_wr_ptr;
   logic [PTR_W-1:0]          r_rd_ptr;

   // Per-entry prediction state; cleared by the sweep, never by reset.
   logic                      r_valid [NUM_ENTRIES];
   logic [1:0]                r_ctr   [NUM_ENTRIES];

   // Update queue storage.
   logic [BUFFER_SIZE-1:0]    r_fifo_pc     [FIFO_DEPTH];
   logic                      r_fifo_taken  [FIFO_DEPTH];
   logic [ADDRESS_WIDTH-1:0]  r_fifo_target [FIFO_DEPTH];

   logic                      w_empty;
   logic                      w_full;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_sweep_wr;
   logic [BUFFER_SIZE-1:0]    w_head_pc;
   logic                      w_head_taken;
   logic [ADDRESS_WIDTH-1:0]  w_head_target;

   // Pointers carry one extra wrap bit: equal low bits with differing MSBs
   // means the queue is full.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                    (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);

   assign w_head_pc     = r_fifo_pc[r_rd_ptr[FIFO_AW-1:0]];
   assign w_head_taken  = r_fifo_taken[r_rd_ptr[FIFO_AW-1:0]];
   assign w_head_target = r_fifo_target[r_rd_ptr[FIFO_AW-1:0]];

   // A flush cycle drops both the incoming request and the pending commit.
   assign w_push     = i_upd_valid & ~w_full & ~i_flush;
   assign w_pop      = (r_state == ST_RUN) & ~w_empty & ~i_flush;
   // Reset is asynchronous, so the sweep write is masked while it is held.
   assign w_sweep_wr = (r_state == ST_SWEEP) & ~i_Reset;

   assign o_busy          = (r_state == ST_SWEEP);
   assign o_upd_ready     = ~w_full;
   assign o_fifo_count    = r_wr_ptr - r_rd_ptr;
   // Only taken commits touch the BTB; not-taken ones just move the counter.
   assign o_btb_wr_en     = w_sweep_wr | (w_pop & w_head_taken);
   assign o_btb_wr_idx    = (r_state == ST_SWEEP) ? r_sweep_idx : w_head_pc;
   assign o_btb_wr_target = (r_state == ST_SWEEP) ? '0 : w_head_target;

   // No bypass: a lookup colliding with a commit sees the pre-commit state.
   assign o_predict_taken = ~o_busy & r_valid[i_pc] & r_ctr[i_pc][1];
   assign o_pred_target   = i_btb_target;

   // Control state: FSM, sweep index and queue pointers.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         r_state     <= ST_SWEEP;
         r_sweep_idx <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
      end else if (i_flush) begin
         r_state     <= ST_SWEEP;
         r_sweep_idx <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
      end else begin
         case (r_state)
            ST_SWEEP: begin
               // Index wraps back to 0 on the last entry, ready for next sweep.
               r_sweep_idx <= r_sweep_idx + 1'b1;
               if (&r_sweep_idx) begin
                  r_state <= ST_RUN;
               end
            end
            default: begin
               if (w_pop) begin
                  r_rd_ptr <= r_rd_ptr + 1'b1;
               end
            end
         endcase
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
      end
   end

   // Queue storage.
   always_ff @(posedge i_Clk) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr[FIFO_AW-1:0]]     <= i_upd_pc;
         r_fifo_taken[r_wr_ptr[FIFO_AW-1:0]]  <= i_upd_taken;
         r_fifo_target[r_wr_ptr[FIFO_AW-1:0]] <= i_upd_target;
      end
   end

   // Valid bits and direction counters.
   always_ff @(posedge i_Clk) begin
      if (w_sweep_wr) begin
         r_valid[r_sweep_idx] <= 1'b0;
         r_ctr[r_sweep_idx]   <= 2'b01;
      end else if (w_pop) begin
         if (w_head_taken) begin
            if (!r_valid[w_head_pc]) begin
               // First taken resolution allocates as weakly taken.
               r_valid[w_head_pc] <= 1'b1;
               r_ctr[w_head_pc]   <= 2'b10;
            end else if (r_ctr[w_head_pc] != 2'b11) begin
               r_ctr[w_head_pc] <= r_ctr[w_head_pc] + 2'b01;
            end
         end else if (r_valid[w_head_pc] && (r_ctr[w_head_pc] != 2'b00)) begin
            r_ctr[w_head_pc] <= r_ctr[w_head_pc] - 2'b01;
         end
      end
   end

endmodule

// File: tb/tb_btb_predict_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btb_predict_ctrl
//
// Directed scenarios followed by randomized traffic. A behavioural model
// (per-entry valid/counter arrays, a queue of pending updates and a sweep
// position) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_btb_predict_ctrl;

   localparam int AW = 22;
   localparam int BS = 4;
   localparam int FD = 4;
   localparam int NE = 2**BS;

   logic           clk = 1'b0;
   logic           rst;
   logic [BS-1:0]  pc;
   logic [AW-1:0]  btb_target;
   logic           pred_taken;
   logic [AW-1:0]  pred_target;
   logic           upd_valid;
   logic           upd_ready;
   logic [BS-1:0]  upd_pc;
   logic           upd_taken;
   logic [AW-1:0]  upd_target;
   logic           flush;
   logic           wr_en;
   logic [BS-1:0]  wr_idx;
   logic [AW-1:0]  wr_target;
   logic           busy;
   logic [$clog2(FD):0] fifo_count;

   always #5 clk = ~clk;

   btb_predict_ctrl #(
      .ADDRESS_WIDTH (AW),
      .BUFFER_SIZE   (BS),
      .FIFO_DEPTH    (FD)
   ) dut (
      .i_Clk           (clk),
      .i_Reset         (rst),
      .i_pc            (pc),
      .i_btb_target    (btb_target),
      .o_predict_taken (pred_taken),
      .o_pred_target   (pred_target),
      .i_upd_valid     (upd_valid),
      .o_upd_ready     (upd_ready),
      .i_upd_pc        (upd_pc),
      .i_upd_taken     (upd_taken),
      .i_upd_target    (upd_target),
      .i_flush         (flush),
      .o_btb_wr_en     (wr_en),
      .o_btb_wr_idx    (wr_idx),
      .o_btb_wr_target (wr_target),
      .o_busy          (busy),
      .o_fifo_count    (fifo_count)
   );

   // ---------------- reference model ----------------
   typedef struct {
      int pc;
      bit taken;
      int target;
   } upd_t;

   upd_t m_q[$];
   bit   m_valid [NE];
   int   m_ctr   [NE];
   bit   m_sweeping;
   int   m_pos;
   bit   last_acc;

   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_sweeping = 1'b1;
      m_pos      = 0;
      m_q.delete();
   endtask

   // Compare every output against what the model predicts for this cycle.
   task automatic check_outputs();
      bit exp_wr;
      bit exp_pred;
      exp_pred = !m_sweeping && m_valid[int'(pc)] && (m_ctr[int'(pc)] >= 2);
      if (m_sweeping) exp_wr = 1'b1;
      else if (!flush && m_q.size() > 0) exp_wr = m_q[0].taken;
      else exp_wr = 1'b0;
      check("busy",        busy,        m_sweeping);
      check("fifo_count",  fifo_count,  m_q.size());
      check("upd_ready",   upd_ready,   m_q.size() < FD);
      check("pred_target", pred_target, btb_target);
      check("pred_taken",  pred_taken,  exp_pred);
      check("wr_en",       wr_en,       exp_wr);
      if (exp_wr) begin
         if (m_sweeping) begin
            check("wr_idx",    wr_idx,    m_pos);
            check("wr_target", wr_target, 0);
         end else begin
            check("wr_idx",    wr_idx,    m_q[0].pc);
            check("wr_target", wr_target, m_q[0].target);
         end
      end
   endtask

   // Advance the model across one rising edge using the current inputs.
   task automatic model_edge();
      upd_t u;
      bit   acc;
      int   p;
      acc = upd_valid && (m_q.size() < FD) && !flush;
      last_acc = acc;
      if (flush) begin
         model_reset();
      end else begin
         if (m_sweeping) begin
            m_valid[m_pos] = 1'b0;
            m_ctr[m_pos]   = 1;
            m_pos++;
            if (m_pos == NE) begin
               m_sweeping = 1'b0;
               m_pos      = 0;
            end
         end else if (m_q.size() > 0) begin
            u = m_q.pop_front();
            p = u.pc;
            if (u.taken) begin
               if (!m_valid[p]) begin
                  m_valid[p] = 1'b1;
                  m_ctr[p]   = 2;
               end else if (m_ctr[p] < 3) begin
                  m_ctr[p]++;
               end
            end else if (m_valid[p] && m_ctr[p] > 0) begin
               m_ctr[p]--;
            end
         end
         if (acc) begin
            u.pc     = int'(upd_pc);
            u.taken  = upd_taken;
            u.target = int'(upd_target);
            m_q.push_back(u);
            $display("txn: accepted pc=%0d taken=%0d target=0x%0h queued=%0d",
                     u.pc, u.taken, u.target, m_q.size());
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic advance();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      upd_valid  = 1'b0;
      flush      = 1'b0;
      pc         = BS'($urandom_range(0, NE-1));
      btb_target = AW'($urandom);
   endtask

   task automatic set_upd(input int p, input bit t, input int a);
      upd_valid  = 1'b1;
      upd_pc     = BS'(p);
      upd_taken  = t;
      upd_target = AW'(a);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] exp_pred_seq;
      bit         got;

      rst = 1'b1;
      upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
      flush = 1'b0; pc = '0; btb_target = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",  busy,       1);
      check("rst_wr_en", wr_en,      0);
      check("rst_count", fifo_count, 0);
      check("rst_ready", upd_ready,  1);
      rst = 1'b0;

      // Full sweep after reset: index steps 0..NE-1 with zero data.
      for (int k = 0; k < NE; k++) begin
         idle();
         sample();
         check("sweep_idx", wr_idx, k);
         check("sweep_tgt", wr_target, 0);
         advance();
      end
      for (int p = 0; p < NE; p++) begin
         idle();
         pc = BS'(p);
         sample();
         check("post_sweep_busy", busy, 0);
         check("post_sweep_pred", pred_taken, 0);
         advance();
      end

      // Single taken update, one-cycle commit latency, then lookup.
      idle(); set_upd(5, 1'b1, 'h1234);
      sample(); advance();
      idle();
      sample();
      check("commit_en",  wr_en,     1);
      check("commit_idx", wr_idx,    5);
      check("commit_tgt", wr_target, 'h1234);
      advance();
      idle(); pc = 5; btb_target = 'h1234;
      sample();
      check("lookup_taken",  pred_taken,  1);
      check("lookup_target", pred_target, 'h1234);
      advance();

      // Counter saturation: three taken then four not-taken on pc=5.
      exp_pred_seq = 7'b0001111;
      for (int i = 0; i < 7; i++) begin
         idle(); set_upd(5, (i < 3), 'h1234);
         sample(); advance();
         idle();
         sample();
         check("ctr_seq_wr_en", wr_en, (i < 3));
         advance();
         idle(); pc = 5;
         sample();
         check("ctr_seq_pred", pred_taken, exp_pred_seq[i]);
         advance();
      end

      // Fill the queue during a sweep; the fifth request must stall.
      idle(); flush = 1'b1;
      sample(); advance();
      for (int j = 0; j < 5; j++) begin
         got = 1'b0;
         for (int c = 0; c < 40 && !got; c++) begin
            idle(); set_upd(j + 1, 1'b1, 'h100 + j);
            sample();
            if (j == 4 && c == 0) check("fifo_full_ready", upd_ready, 0);
            advance();
            got = last_acc;
         end
         if (!got) check("push_timeout", 0, 1);
      end
      for (int c = 0; c < 8; c++) begin
         idle(); sample(); advance();
      end

      // Flush collides with a pending commit of pc=3.
      idle(); set_upd(3, 1'b1, 'h3333);
      sample(); advance();
      idle(); flush = 1'b1;
      sample();
      check("flush_no_wr", wr_en, 0);
      advance();
      idle();
      sample();
      check("flush_busy",  busy,       1);
      check("flush_count", fifo_count, 0);
      check("flush_idx0",  wr_idx,     0);
      advance();
      for (int c = 0; c < 40 && m_sweeping; c++) begin
         idle(); sample(); advance();
      end
      idle(); pc = 3;
      sample();
      check("flush_pc3_pred", pred_taken, 0);
      advance();

      // Reset pulsed between edges in the middle of a sweep.
      idle(); flush = 1'b1;
      sample(); advance();
      for (int c = 0; c < 7; c++) begin
         idle(); set_upd(c, 1'b1, c);
         sample(); advance();
      end
      idle();
      #3 rst = 1'b1;
      #1;
      check("midrst_busy",  busy,       1);
      check("midrst_wr_en", wr_en,      0);
      check("midrst_count", fifo_count, 0);
      check("midrst_ready", upd_ready,  1);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      for (int k = 0; k < NE; k++) begin
         idle();
         sample();
         check("resweep_idx", wr_idx, k);
         advance();
      end
      idle();
      sample();
      check("resweep_done", busy, 0);
      advance();

      // Randomized traffic.
      for (int c = 0; c < 800; c++) begin
         idle();
         upd_valid  = ($urandom_range(0, 2) != 0);
         upd_pc     = BS'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NE-1)
                                                      : $urandom_range(0, 3));
         upd_taken  = ($urandom_range(0, 2) != 0);
         upd_target = AW'($urandom);
         pc         = BS'($urandom_range(0, 5));
         flush      = ($urandom_range(0, 99) == 0);
         sample();
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
